// File: rtl/plic_mt_if.sv
// Bundle between the APB register shell and the multi-target PLIC core:
// raw sources, per-target configuration, claim/complete strobes and core results.
interface plic_mt_if #(
  parameter int NUM_SRC = 64,
  parameter int NUM_TGT = 2,
  parameter int PRIO_W  = 3
);
  localparam int ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]         irq_i;
  logic [NUM_SRC-1:0]         tm_i;
  logic [NUM_SRC*PRIO_W-1:0]  prio_i;
  logic [NUM_TGT*NUM_SRC-1:0] ie_i;
  logic [NUM_TGT*PRIO_W-1:0]  thold_i;
  logic [NUM_TGT-1:0]         claim_i;
  logic [NUM_TGT-1:0]         comp_i;
  logic [NUM_TGT*ID_W-1:0]    comp_id_i;
  logic [NUM_SRC-1:0]         ip_o;
  logic [NUM_TGT*ID_W-1:0]    claim_id_o;
  logic [NUM_TGT-1:0]         irq_o;

  modport master (
    output irq_i, tm_i, prio_i, ie_i, thold_i, claim_i, comp_i, comp_id_i,
    input  ip_o, claim_id_o, irq_o
  );

  modport slave (
    input  irq_i, tm_i, prio_i, ie_i, thold_i, claim_i, comp_i, comp_id_i,
    output ip_o, claim_id_o, irq_o
  );
endinterface

// File: rtl/plic_mt_core.sv
// Multi-target PLIC core: per-source gateways with edge pending counters, pending
// bits, per-target enable/threshold arbitration and claim/complete handling.
module plic_mt_core #(
  parameter int NUM_SRC = 64,
  parameter int NUM_TGT = 2,
  parameter int PRIO_W  = 3,
  parameter int ECNT_W  = 2
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  plic_mt_if.slave bus
);
  localparam int ID_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    GW_IDLE     = 2'd0,
    GW_PEND     = 2'd1,
    GW_INFLIGHT = 2'd2
  } gw_state_e;

  logic [NUM_SRC-1:1] irq_q_reg;
  logic [NUM_SRC-1:1] irq_q_d_reg;
  logic [NUM_SRC-1:1] tm_q_reg;
  logic [NUM_SRC-1:0] ip;
  logic [PRIO_W-1:0]  prio     [NUM_SRC];
  logic [NUM_SRC-1:0] ie       [NUM_TGT];
  logic [PRIO_W-1:0]  thold    [NUM_TGT];
  logic [ID_W-1:0]    comp_id  [NUM_TGT];
  logic [ID_W-1:0]    best_q   [NUM_TGT];
  logic [ID_W-1:0]    claim_id [NUM_TGT];
  logic               unused_src0;

  // Source 0 is reserved, so its raw input and mode bit are never looked at.
  assign unused_src0 = bus.irq_i[0] ^ bus.tm_i[0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq_q_reg   <= '0;
      irq_q_d_reg <= '0;
      tm_q_reg    <= '0;
    end else begin
      irq_q_reg   <= bus.irq_i[NUM_SRC-1:1];
      irq_q_d_reg <= irq_q_reg;
      tm_q_reg    <= bus.tm_i[NUM_SRC-1:1];
    end
  end

  // A lower-indexed target asking for the same ID wins; the others read 0.
  always_comb begin
    for (int t = 0; t < NUM_TGT; t++) begin
      claim_id[t] = '0;
      if (bus.claim_i[t] && best_q[t] != '0 && ip[best_q[t]]) begin
        claim_id[t] = best_q[t];
        for (int u = 0; u < NUM_TGT; u++) begin
          if (u < t && bus.claim_i[u] && best_q[u] == best_q[t]) begin
            claim_id[t] = '0;
          end
        end
      end
    end
  end

  genvar gi;

  for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign prio[gi] = bus.prio_i[gi*PRIO_W +: PRIO_W];

    if (gi == 0) begin : g_rsvd
      assign ip[gi] = 1'b0;
    end else begin : g_gw
      gw_state_e         state_reg, state_next;
      logic [ECNT_W-1:0] ecnt_reg, ecnt_next;
      logic              edge_hit, claim_hit, comp_hit, ip_bit;

      always_comb begin
        edge_hit  = irq_q_reg[gi] & ~irq_q_d_reg[gi];
        claim_hit = 1'b0;
        comp_hit  = 1'b0;
        for (int t = 0; t < NUM_TGT; t++) begin
          claim_hit = claim_hit | (claim_id[t] == ID_W'(gi));
          comp_hit  = comp_hit | (bus.comp_i[t] && comp_id[t] == ID_W'(gi) && ie[t][gi]);
        end
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          state_reg <= GW_IDLE;
          ecnt_reg  <= '0;
        end else begin
          state_reg <= state_next;
          ecnt_reg  <= ecnt_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        case (state_reg)
          GW_IDLE: begin
            if (bus.tm_i[gi] ? (edge_hit || ecnt_reg != '0) : irq_q_reg[gi]) begin
              state_next = GW_PEND;
            end
          end
          GW_PEND:     if (claim_hit) state_next = GW_INFLIGHT;
          GW_INFLIGHT: if (comp_hit)  state_next = GW_IDLE;
          default:     state_next = GW_IDLE;
        endcase
      end

      // An edge in IDLE pends directly; a stored edge is spent only when no fresh one arrives.
      always_comb begin
        ecnt_next = ecnt_reg;
        if (bus.tm_i[gi] != tm_q_reg[gi]) begin
          ecnt_next = '0;
        end else if (bus.tm_i[gi]) begin
          if (state_reg == GW_IDLE) begin
            if (!edge_hit && ecnt_reg != '0) ecnt_next = ecnt_reg - ECNT_W'(1);
          end else if (edge_hit && ecnt_reg != {ECNT_W{1'b1}}) begin
            ecnt_next = ecnt_reg + ECNT_W'(1);
          end
        end
      end

      always_comb begin
        ip_bit = (state_reg == GW_PEND);
      end

      assign ip[gi] = ip_bit;
    end
  end

  for (gi = 0; gi < NUM_TGT; gi++) begin : g_tgt
    logic [ID_W-1:0]   best_id, best_id_reg;
    logic [PRIO_W-1:0] best_prio;
    logic              irq_reg;

    assign ie[gi]      = bus.ie_i[gi*NUM_SRC +: NUM_SRC];
    assign thold[gi]   = bus.thold_i[gi*PRIO_W +: PRIO_W];
    assign comp_id[gi] = bus.comp_id_i[gi*ID_W +: ID_W];

    // Strict compare during an ascending scan keeps the lowest ID on priority ties.
    always_comb begin
      best_id   = '0;
      best_prio = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (ip[i] && ie[gi][i] && prio[i] > thold[gi] && prio[i] > best_prio) begin
          best_id   = ID_W'(i);
          best_prio = prio[i];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        best_id_reg <= '0;
        irq_reg     <= 1'b0;
      end else begin
        best_id_reg <= best_id;
        irq_reg     <= (best_id != '0);
      end
    end

    assign best_q[gi]                         = best_id_reg;
    assign bus.irq_o[gi]                      = irq_reg;
    assign bus.claim_id_o[gi*ID_W +: ID_W]    = claim_id[gi];
  end

  assign bus.ip_o = ip;

endmodule
